// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared frame constants, state encoding and parity helper for the serial tx arbiter
package serial_tx_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } tx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// rtl/serial_tx_shifter.sv - byte shift register and bit counter feeding the serial frame FSM
module serial_tx_shifter
    import serial_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 shift,
    output logic                 cur_bit,
    output logic                 next_bit,
    output logic                 last_bit
);

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           cnt_q, cnt_d;

    // Load restarts the bit count; each shift drops the bit just sent.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = 3'd0;
        end else if (shift) begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cur_bit  = shift_q[0];
    assign next_bit = shift_q[1];
    assign last_bit = (cnt_q == 3'(DATA_BITS - 1));

endmodule

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin arbiter and start/data/stop framer on one serial line; optional parity via SERIAL_TX_ARB_PARITY_EN
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GAP_BITS = 1,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic                   done
);

    tx_state_e      state_q, state_d;
    logic           tx_q, tx_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic           found;
    logic [IDW-1:0] sel;
    int             idx;
    logic           load, shift;
    logic           cur_bit, next_bit, last_bit;
`ifdef SERIAL_TX_ARB_PARITY_EN
    logic           parity_q, parity_d;
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_q) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    // Ready only in IDLE, and held low while reset is asserted.
    assign req_ready = (state_q == ST_IDLE && found && reset) ? (NUM_REQ'(1) << sel) : '0;

    // Frame sequencing; tx_d is the line level of the next state.
    always_comb begin
        state_d    = state_q;
        tx_d       = IDLE_LVL;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        load       = 1'b0;
        shift      = 1'b0;
`ifdef SERIAL_TX_ARB_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_START;
                    tx_d       = START_LVL;
                    load       = 1'b1;
                    grant_id_d = sel;
                    last_d     = sel;
`ifdef SERIAL_TX_ARB_PARITY_EN
                    parity_d   = even_parity(req_data[int'(sel)*8 +: 8]);
`endif
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                tx_d    = cur_bit;
            end
            ST_DATA: begin
                if (last_bit) begin
`ifdef SERIAL_TX_ARB_PARITY_EN
                    state_d = ST_PARITY;
                    tx_d    = parity_q;
`else
                    state_d = ST_STOP;
                    tx_d    = STOP_LVL;
`endif
                end else begin
                    shift = 1'b1;
                    tx_d  = next_bit;
                end
            end
`ifdef SERIAL_TX_ARB_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
                tx_d    = STOP_LVL;
            end
`endif
            ST_STOP: begin
                gap_cnt_d = 4'd0;
                state_d   = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
                tx_d      = IDLE_LVL;
            end
            ST_GAP: begin
                tx_d = IDLE_LVL;
                if (gap_cnt_q == 4'(GAP_BITS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LVL;
            end
        endcase
    end

    // Registered state, line level, grant and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_q       <= IDLE_LVL;
            grant_id_q <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            gap_cnt_q  <= 4'd0;
`ifdef SERIAL_TX_ARB_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SERIAL_TX_ARB_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    serial_tx_shifter u_shifter (
        .clk       (clk),
        .rst_n     (reset),
        .load      (load),
        .load_data (req_data[int'(sel)*8 +: 8]),
        .shift     (shift),
        .cur_bit   (cur_bit),
        .next_bit  (next_bit),
        .last_bit  (last_bit)
    );

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_STOP);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed self-checking bench for serial_tx_arbiter (default build)
module tb_serial_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        done;

    int tests_run;
    int tests_failed;
    int cyc;

    serial_tx_arbiter #(.NUM_REQ(4), .GAP_BITS(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for an acceptance, checks which requester got it,
    // then returns at the negedge of the start-bit cycle.
    task automatic wait_accept(input int exp_id, output int at);
        int n;
        n = 0;
        #1;
        while (req_ready == 4'b0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("req_ready", 32'(req_ready), 32'(1) << exp_id);
        at = cyc;
        @(posedge clk);
        @(negedge clk);
        check("grant_id", 32'(grant_id), 32'(exp_id));
        check("busy_start", 32'(busy), 32'd1);
        check("tx_start", 32'(tx), 32'd0);
        check("ready_low", 32'(req_ready), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int t0, t1;
        logic [9:0] exp_bits;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        reset        = 1'b0;
        req_valid    = 4'b0001;
        req_data     = 32'h0;

        // Reset state, with a request pending to prove ready stays low
        #12;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 4'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Single frame 8'hA5 from requester 0; data changed after acceptance
        req_data  = {8'h11, 8'h22, 8'h33, 8'hA5};
        req_valid = 4'b0001;
        wait_accept(0, t0);
        req_valid     = 4'b0;
        req_data[7:0] = 8'h00;
        exp_bits      = {2'b11, 8'hA5};
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("a5_tx_k%0d", i + 1), 32'(tx), 32'(exp_bits[i-1]));
            check($sformatf("a5_done_k%0d", i + 1), 32'(done), (i == 9) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("a5_busy_k12", 32'(busy), 32'd0);

        // All four continuously valid: 0,1,2,3,0 at a 12-cycle period
        reset_pulse();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'hF;
        wait_accept(0, t0);
        for (int g = 1; g <= 4; g++) begin
            wait_accept(g % 4, t1);
            check("rr_period", 32'(t1 - t0), 32'd12);
            t0 = t1;
        end
        req_valid = 4'b0;
        repeat (14) @(negedge clk);

        // Requester 2 alone, then 1 raised during 2's data bits
        reset_pulse();
        req_valid = 4'b0100;
        wait_accept(2, t0);
        req_valid = 4'b0;
        repeat (3) @(negedge clk);
        req_valid = 4'b0010;
        wait_accept(1, t1);
        check("late_period", 32'(t1 - t0), 32'd12);
        req_valid = 4'hF;
        wait_accept(2, t0);
        wait_accept(3, t0);
        wait_accept(0, t0);
        wait_accept(1, t0);
        req_valid = 4'b0;
        repeat (14) @(negedge clk);

        // Reset mid-frame at data bit 4, then next grant goes to requester 0
        reset_pulse();
        req_data  = {8'h44, 8'h00, 8'h22, 8'h11};
        req_valid = 4'b0100;
        wait_accept(2, t0);
        req_valid = 4'b0001;
        repeat (5) @(negedge clk);
        check("mid_tx_bit4", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_accept(0, t0);
        req_valid = 4'b0;
        repeat (14) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one outgoing serial line among `NUM_REQ` byte requesters, using the team's standard frame: start bit 0, 8 data bits LSB first, stop bit 1, one bit per clock. A round-robin arbiter grants one requester per frame. The FSM sequences the start/data/stop bits onto `tx`, producing frames that the team's serial-frame receiver accepts directly. It sits between the byte-producing engines and the serial pin.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `GAP_BITS`, 1: extra idle-high cycles after each stop bit, 0..15.

- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: requester i has a byte pending.
- `req_data` input NUM_REQ*8: byte of requester i at bits [8i+7:8i].
- `req_ready` output NUM_REQ: one-hot, combinational; high for one cycle when requester i's byte is accepted.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: frame in progress (state != IDLE).
- `grant_id` output $clog2(NUM_REQ): index of the requester whose frame is on `tx`; registered.
- `done` output 1: high during the stop-bit cycle.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `grant_id`=0, `req_ready`=0, state IDLE, shift register 0, round-robin last-grant = NUM_REQ-1 so requester 0 has top priority first.
- States: IDLE, START, DATA, [PARITY], STOP, GAP.
- IDLE:
  - If any `req_valid` is high, select the first valid requester searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Assert its `req_ready` this cycle.
  - Latch its byte into the shift register and its index into `grant_id` and last-grant.
  - Go to START.
- START: `tx`=0 for 1 cycle, then DATA.
- DATA: `tx`=shift[0] for 8 cycles; shift right each cycle; 3-bit counter; after bit 7 go to STOP (or PARITY).
- STOP: `tx`=1 and `done`=1 for 1 cycle. Go to GAP if GAP_BITS>0, else IDLE.
- GAP: `tx`=1 for GAP_BITS cycles, then IDLE.
- Handshake:
  - A requester holds `req_valid` and its data stable until it sees `req_ready`.
  - Dropping `req_valid` before grant is legal; nothing is latched.
  - `req_ready` is never asserted outside IDLE.
- Changes to `req_data` after acceptance do not affect the frame in flight.
- Reset asserted mid-frame:
  - Immediately forces `tx`=1 and all outputs to their reset values.
  - The frame is abandoned, not resumed.
  - Round-robin pointer returns to its reset value.

## Timing
- Acceptance is in cycle k (`req_ready` high).
- Start bit in k+1; data bit i in k+2+i; stop bit and `done` in k+10.
- GAP occupies k+11..k+10+GAP_BITS. IDLE is in k+11+GAP_BITS, the earliest next acceptance.
- Frame period is 11+GAP_BITS cycles (12+GAP_BITS with parity). The accept cycle guarantees at least one idle-high cycle between frames.
- `tx` is registered: the flop loads the value for the next state, so `tx` always matches the current state with no decode glitches.
- `busy` rises in k+1 and falls in the first IDLE cycle.

## Configuration
- `SERIAL_TX_ARB_PARITY_EN` defined:
  - PARITY state is inserted after DATA. `tx` = XOR of the 8 data bits (even parity) for 1 cycle.
  - STOP and `done` move to k+11.
- Undefined: no PARITY state or parity logic; frame as above.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum;
  - `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1, `IDLE_LVL`=1;
  - the parity helper function.
- Sub-module `serial_tx_shifter` holds the 8-bit shift register and bit counter: load, shift, `last_bit` flag. The arbiter and FSM stay in the top module.

## Test plan
- Single request: requester 0 sends 8'hA5, GAP_BITS=1 -> `tx` sequence from k+1 is 0,1,0,1,0,0,1,0,1,1,1. `done` high only at k+10; IDLE at k+12.
- All four valid continuously:
  - Grants in order 0,1,2,3,0 with `grant_id` matching.
  - Exactly one `req_ready` per frame.
  - 12-cycle frame period.
- Requester 2 valid alone, then requester 1 raised during 2's DATA -> 1 is granted at the next IDLE. The pointer then favours 2,3,0 before 1 again.
- Reset driven low at data bit 4 of a frame -> `tx`=1 in the same cycle without a clock edge. All outputs return to reset values; the next grant after reset goes to requester 0.
- `req_data` changed the cycle after acceptance -> the transmitted byte equals the value latched at acceptance.
- With `SERIAL_TX_ARB_PARITY_EN`, byte 8'h07 -> parity bit 1 at k+10; stop bit and `done` at k+11.
